// File: rtl/response_compactor.sv
// Response compactor: folds a stream of 2-bit test responses into a 16-bit
// MISR signature (x^16+x^12+x^5+1) over a programmed number of patterns, then
// compares the final signature against a golden value.
//
// Handshake: a response {po2, po1} is transferred on a rising edge where
// resp_valid && resp_ready. resp_ready is high only while a run is active. The
// producer may raise resp_valid at any time and keep it high. Responses offered
// outside a run are dropped, not stalled.
module response_compactor #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 12
) (
    input  logic             sys_clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] seed,
    input  logic [SIG_W-1:0] expected,
    input  logic             po1,
    input  logic             po2,
    input  logic             resp_valid,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_q;
    logic [SIG_W-1:0] expected_q;
    logic [SIG_W-1:0] misr_next;
    logic [CNT_W-1:0] count_inc;
    logic             fb;
    logic             accept;

    assign fb        = signature[SIG_W-1];
    assign count_inc = count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign accept    = resp_valid && resp_ready;

    // Status outputs decode straight from the registered state, so they are glitch-free.
    assign resp_ready = (state == ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign state_dbg  = state;

    // MISR next-state: shift up by one, feed the top bit back into taps 0, 5 and 12, inject d into bits 0 and 1.
    always_comb begin
        misr_next     = {signature[SIG_W-2:0], 1'b0};
        misr_next[0]  = fb ^ po1;
        misr_next[1]  = signature[0] ^ po2;
        misr_next[5]  = signature[4] ^ fb;
        misr_next[12] = signature[11] ^ fb;
    end

    // Run controller: latches the run parameters, steps the MISR per accepted response and grades the result.
    always_ff @(posedge sys_clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            num_q      <= '0;
            expected_q <= '0;
            signature  <= '0;
            count      <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_q      <= num_patterns;
                        expected_q <= expected;
                        signature  <= seed;
                        count      <= '0;
                        pass       <= 1'b0;
                        // An empty run has nothing to compact and grades the seed directly.
                        state      <= (num_patterns == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        signature <= misr_next;
                        count     <= count_inc;
                        if (count_inc == num_q) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    pass  <= (signature == expected_q);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_response_compactor.sv
// Self-checking bench for response_compactor: directed vectors plus randomized
// runs graded against a polynomial-division model of the MISR.
module tb_response_compactor;

    localparam int SIG_W = 16;
    localparam int CNT_W = 12;

    logic             sys_clk;
    logic             rstb;
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [SIG_W-1:0] seed;
    logic [SIG_W-1:0] expected;
    logic             po1;
    logic             po2;
    logic             resp_valid;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] count;
    logic [1:0]       state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [SIG_W-1:0] exp_q[$];

    response_compactor #(.SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
        .sys_clk      (sys_clk),
        .rstb         (rstb),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .expected     (expected),
        .po1          (po1),
        .po2          (po2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count),
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: multiply by x modulo x^16+x^12+x^5+1, then add the response word.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [1:0] d);
        logic [15:0] r;
        r = (s << 1) ^ {14'd0, d};
        if (s[15]) r = r ^ 16'h1021;
        return r;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_start(input logic [CNT_W-1:0] np, input logic [SIG_W-1:0] sd,
                               input logic [SIG_W-1:0] ex);
        start = 1'b1; num_patterns = np; seed = sd; expected = ex;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_resp(input logic v, input logic [1:0] d);
        resp_valid = v;
        {po2, po1} = d;
    endtask

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0; num_patterns = '0; seed = '0; expected = '0;
        po1 = 1'b0; po2 = 1'b0; resp_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (resp_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", resp_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL rst_pass got %b want 0", pass); end
        n_cmp++; if (signature !== 16'h0000) begin n_err++; $display("FAIL rst_sig got %h want 0000", signature); end
        n_cmp++; if (count !== 12'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        #2 rstb = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_release_busy got %b want 0", busy); end
    endtask

    task automatic test_misr_basic();
        drive_start(12'd2, 16'h0000, 16'h0000);
        n_cmp++; if (resp_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", resp_ready); end
        n_cmp++; if (signature !== 16'h0000) begin n_err++; $display("FAIL basic_seed got %h want 0000", signature); end
        drive_resp(1'b1, 2'b01);
        tick();
        n_cmp++; if (signature !== 16'h0001) begin n_err++; $display("FAIL basic_sig1 got %h want 0001", signature); end
        n_cmp++; if (count !== 12'd1) begin n_err++; $display("FAIL basic_cnt1 got %0d want 1", count); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done1 got %b want 0", done); end
        tick();
        drive_resp(1'b0, 2'b00);
        n_cmp++; if (signature !== 16'h0003) begin n_err++; $display("FAIL basic_sig2 got %h want 0003", signature); end
        n_cmp++; if (count !== 12'd2) begin n_err++; $display("FAIL basic_cnt2 got %0d want 2", count); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done2 got %b want 1", done); end
        n_cmp++; if (resp_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_done got %b want 0", resp_ready); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", busy); end
        n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL basic_pass got %b want 0", pass); end
        n_cmp++; if (signature !== 16'h0003) begin n_err++; $display("FAIL basic_hold got %h want 0003", signature); end
    endtask

    task automatic test_pass_fail();
        drive_start(12'd1, 16'h8000, 16'h1021);
        drive_resp(1'b1, 2'b00);
        tick();
        drive_resp(1'b0, 2'b00);
        n_cmp++; if (signature !== 16'h1021) begin n_err++; $display("FAIL pf_sig got %h want 1021", signature); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pf_done got %b want 1", done); end
        n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL pf_pass_early got %b want 0", pass); end
        tick();
        n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL pf_pass got %b want 1", pass); end
        tick(); tick();
        n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL pf_pass_hold got %b want 1", pass); end
        drive_start(12'd1, 16'h8000, 16'h1020);
        n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL pf_pass_clear got %b want 0", pass); end
        drive_resp(1'b1, 2'b00);
        tick();
        drive_resp(1'b0, 2'b00);
        tick();
        n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL pf_fail got %b want 0", pass); end
        n_cmp++; if (signature !== 16'h1021) begin n_err++; $display("FAIL pf_sig2 got %h want 1021", signature); end
    endtask

    task automatic test_zero_patterns();
        logic saw_ready;
        saw_ready = 1'b0;
        drive_resp(1'b1, 2'b11);
        drive_start(12'd0, 16'hABCD, 16'hABCD);
        saw_ready |= resp_ready;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", done); end
        n_cmp++; if (signature !== 16'hABCD) begin n_err++; $display("FAIL zero_sig got %h want abcd", signature); end
        tick();
        saw_ready |= resp_ready;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse got %b want 0", done); end
        n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL zero_pass got %b want 1", pass); end
        n_cmp++; if (count !== 12'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", count); end
        n_cmp++; if (signature !== 16'hABCD) begin n_err++; $display("FAIL zero_sig_hold got %h want abcd", signature); end
        n_cmp++; if (saw_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready got %b want 0", saw_ready); end
        drive_resp(1'b0, 2'b00);
    endtask

    task automatic test_gaps_and_ignored();
        logic [1:0]  d[3];
        logic [15:0] s0;
        logic [15:0] m;
        int          cnt;
        s0 = 16'($urandom);
        m = s0;
        for (int i = 0; i < 3; i++) begin
            d[i] = 2'($urandom_range(0, 3));
            m = ref_step(m, d[i]);
        end
        drive_start(12'd3, s0, m);
        m = s0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 2; g++) begin
                drive_resp(1'b0, 2'b11);
                start = 1'b1; num_patterns = 12'd1; seed = ~s0; expected = ~m;
                tick();
                start = 1'b0;
                n_cmp++; if (signature !== m) begin n_err++; $display("FAIL gap_sig got %h want %h", signature, m); end
                n_cmp++; if (count !== 12'(cnt)) begin n_err++; $display("FAIL gap_count got %0d want %0d", count, cnt); end
            end
            drive_resp(1'b1, d[i]);
            tick();
            m = ref_step(m, d[i]);
            cnt++;
            n_cmp++; if (signature !== m) begin n_err++; $display("FAIL gap_acc_sig got %h want %h", signature, m); end
            n_cmp++; if (done !== logic'(cnt == 3)) begin n_err++; $display("FAIL gap_done got %b want %b", done, cnt == 3); end
        end
        // In DONE: both start and a valid response must be ignored
        start = 1'b1; num_patterns = 12'd5; seed = 16'h1234; expected = 16'h4321;
        drive_resp(1'b1, 2'b10);
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy got %b want 0", busy); end
        n_cmp++; if (count !== 12'd3) begin n_err++; $display("FAIL ign_count got %0d want 3", count); end
        n_cmp++; if (signature !== m) begin n_err++; $display("FAIL ign_sig got %h want %h", signature, m); end
        n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL ign_pass got %b want 1", pass); end
        tick(); tick();
        n_cmp++; if (signature !== m) begin n_err++; $display("FAIL idle_sig got %h want %h", signature, m); end
        n_cmp++; if (count !== 12'd3) begin n_err++; $display("FAIL idle_count got %0d want 3", count); end
        drive_resp(1'b0, 2'b00);
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s0;
        logic [15:0] m;
        logic [1:0]  d0;
        logic [1:0]  d1;
        s0 = 16'($urandom);
        drive_start(12'd4, s0, 16'h0000);
        drive_resp(1'b1, 2'b01);
        tick();
        drive_resp(1'b0, 2'b00);
        n_cmp++; if (count !== 12'd1) begin n_err++; $display("FAIL abort_pre_count got %0d want 1", count); end
        #2 rstb = 1'b0;
        #1;
        n_cmp++; if ({resp_ready, busy, done, pass} !== 4'b0000) begin n_err++; $display("FAIL abort_flags got %b want 0000", {resp_ready, busy, done, pass}); end
        n_cmp++; if (signature !== 16'h0000) begin n_err++; $display("FAIL abort_sig got %h want 0000", signature); end
        n_cmp++; if (count !== 12'd0) begin n_err++; $display("FAIL abort_count got %0d want 0", count); end
        drive_resp(1'b1, 2'b11);
        tick();
        rstb = 1'b1;
        tick();
        n_cmp++; if ({busy, done, count} !== {2'b00, 12'd0}) begin n_err++; $display("FAIL abort_after got %b/%b/%0d want 0/0/0", busy, done, count); end
        drive_resp(1'b0, 2'b00);
        // Fresh full run after release
        s0 = 16'($urandom);
        d0 = 2'($urandom_range(0, 3));
        d1 = 2'($urandom_range(0, 3));
        m = ref_step(ref_step(s0, d0), d1);
        drive_start(12'd2, s0, m);
        drive_resp(1'b1, d0);
        tick();
        drive_resp(1'b1, d1);
        tick();
        drive_resp(1'b0, 2'b00);
        n_cmp++; if (signature !== m) begin n_err++; $display("FAIL fresh_sig got %h want %h", signature, m); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fresh_done got %b want 1", done); end
        tick();
        n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL fresh_pass got %b want 1", pass); end
    endtask

    task automatic test_random();
        logic [1:0]  d_arr[8];
        logic [15:0] s0;
        logic [15:0] m;
        logic [15:0] fin;
        logic [15:0] ex;
        logic [15:0] want;
        logic        v;
        int          np;
        int          idx;
        int          budget;
        for (int run = 0; run < 8; run++) begin
            np = $urandom_range(1, 8);
            s0 = 16'($urandom);
            fin = s0;
            for (int i = 0; i < np; i++) begin
                d_arr[i] = 2'($urandom_range(0, 3));
                fin = ref_step(fin, d_arr[i]);
            end
            ex = ($urandom_range(0, 1) == 1) ? fin : (fin ^ 16'h0100);
            exp_q.delete();
            drive_start(12'(np), s0, ex);
            m = s0;
            idx = 0;
            budget = 0;
            while (idx < np && budget < 200) begin
                v = 1'($urandom_range(0, 1));
                drive_resp(v, d_arr[idx]);
                if (v) begin
                    m = ref_step(m, d_arr[idx]);
                    exp_q.push_back(m);
                end
                tick();
                budget++;
                if (v) begin
                    want = exp_q.pop_front();
                    idx++;
                    n_cmp++; if (signature !== want) begin n_err++; $display("FAIL rnd_sig run %0d got %h want %h", run, signature, want); end
                end
                n_cmp++; if (count !== 12'(idx)) begin n_err++; $display("FAIL rnd_count run %0d got %0d want %0d", run, count, idx); end
                n_cmp++; if (done !== logic'(v && idx == np)) begin n_err++; $display("FAIL rnd_done run %0d got %b want %b", run, done, v && idx == np); end
            end
            n_cmp++; if (idx != np) begin n_err++; $display("FAIL rnd_budget run %0d accepted %0d want %0d", run, idx, np); end
            drive_resp(1'b0, 2'b00);
            tick();
            n_cmp++; if (pass !== logic'(ex == fin)) begin n_err++; $display("FAIL rnd_pass run %0d got %b want %b", run, pass, ex == fin); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle run %0d got %b want 0", run, busy); end
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_misr_basic();
        test_pass_fail();
        test_zero_patterns();
        test_gaps_and_ignored();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/response_compactor.md
RESPONSE_COMPACTOR -- requirements
Module: response_compactor

Interface
REQ-001 Parameter SIG_W, default 16, signature (MISR) width; fixed polynomial below requires SIG_W=16.
REQ-002 Parameter CNT_W, default 12, pattern-count width.
REQ-003 sys_clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to sys_clk.
REQ-005 start  input  1  begin a compaction run; sampled only in IDLE.
REQ-006 num_patterns  input  CNT_W  number of responses to compact; latched on accepted start.
REQ-007 seed  input  SIG_W  initial MISR value; latched on accepted start.
REQ-008 expected  input  SIG_W  golden signature; latched on accepted start.
REQ-009 po1, po2  input  1 each  response bits from the upstream test-logic stage; d = {po2, po1}.
REQ-010 resp_valid  input  1  {po2, po1} valid this cycle.
REQ-011 resp_ready  output  1  compactor accepts a response this cycle.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse at run end.
REQ-014 pass  output  1  signature == expected for last completed run; held until next accepted start.
REQ-015 signature  output  SIG_W  current MISR contents.
REQ-016 count  output  CNT_W  responses accepted in current/last run.

Function
REQ-017 FSM states IDLE, RUN, DONE; exactly one active; encoding free.
REQ-018 IDLE: start=1 -> latch num_patterns/seed/expected, signature<=seed, count<=0, pass<=0; go RUN, or DONE directly if num_patterns==0.
REQ-019 resp_ready SHALL be 1 only in RUN (combinational from state); accept = resp_valid & resp_ready.
REQ-020 Each accept updates the MISR in the same edge, with s = signature and f = s[15]: next[0]=f^d[0]; next[1]=s[0]^d[1]; next[5]=s[4]^f; next[12]=s[11]^f; all other next[i]=s[i-1] (polynomial x^16+x^12+x^5+1).
REQ-021 Each accept increments count by 1; count never wraps within a run (bounded by num_patterns).
REQ-022 RUN -> DONE on the accept that makes count equal to latched num_patterns; no further accepts after it.
REQ-023 resp_valid=0 in RUN: signature and count hold; no timeout.
REQ-024 DONE lasts exactly one cycle: done=1, pass<=(signature==expected_latched) registered at the DONE->IDLE edge and visible from the following cycle; then IDLE.
REQ-025 start while RUN or DONE SHALL be ignored; latched inputs SHALL not change mid-run.
REQ-026 resp_valid in IDLE or DONE SHALL be ignored (no MISR update, no count change).
REQ-027 signature and count SHALL hold their final values in IDLE until the next accepted start.
REQ-028 Latency: first accept possible the cycle after start; done asserted the cycle after the final accept; pass valid the cycle after done.

Reset
REQ-029 rstb=0 SHALL force, asynchronously: state IDLE, resp_ready=0, busy=0, done=0, pass=0, signature=0, count=0, all latched inputs 0.
REQ-030 rstb asserted mid-RUN SHALL abort the run with no done pulse; a new start is required after release.

Verification
REQ-031 Seed 0x0000, num_patterns=2, responses d=01, d=01 back-to-back -> signature 0x0001 then 0x0003, count=2, done one cycle after second accept.
REQ-032 Seed 0x8000, num_patterns=1, d=00 -> signature 0x1021; expected=0x1021 -> pass=1; expected=0x1020 -> pass=0.
REQ-033 num_patterns=0, seed 0xABCD, expected 0xABCD -> RUN skipped, done pulse one cycle after start, signature 0xABCD, pass=1, resp_ready never 1.
REQ-034 num_patterns=3 with resp_valid gaps of 2 cycles and start/resp_valid pulsed during DONE and IDLE -> only 3 accepts counted, ignored start/valid change nothing.
REQ-035 rstb driven low between clock edges mid-RUN (count=1) -> all outputs 0 immediately, no done; after release start runs a fresh full compaction correctly.
